div_unit: RTL

- Sequential signed 32-bit divider for the multicycle MIPS datapath, implementing DIV.
- Sits directly downstream of the DivSrcA/DivSrcB operand muxes and consumes their outputs as dividend and divisor.
- Produces quotient (LO) and remainder (HI) for the HI/LO registers.
- Raises a divide-by-zero flag that the control unit routes to the exception path.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/div_unit_if.sv | 29 ++
 rtl/div_step.sv | 28 ++
 rtl/div_unit.sv | 139 +++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the sequential divider: divider FSM states,
// operand width and iteration-counter width.
package cpu_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ITER,
    FIX,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_unit_if.sv
// Request/result bundle between the DivSrcA/DivSrcB operand muxes, the
// control unit and the divider. The master drives the request; the slave
// (div_unit) returns status and the HI/LO results.
interface div_unit_if
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, dividend, divisor,
    input  busy, done, div0, hi_out, lo_out
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, div0, hi_out, lo_out
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift {rem,quo}
// left by one, trial-subtract the divisor and keep the result if it is
// non-negative, recording the outcome in the quotient LSB.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;

  // Shift-and-trial-subtract at WIDTH+1 bits so the sign bit is the borrow.
  always_comb begin
    w_shift = {i_rem, i_quo[WIDTH-1]};
    w_trial = w_shift - {1'b0, i_dvs};
    o_rem   = w_shift[WIDTH-1:0];
    if (!w_trial[WIDTH]) begin
      o_rem = w_trial[WIDTH-1:0];
    end
    o_quo = {i_quo[WIDTH-2:0], ~w_trial[WIDTH]};
  end

endmodule

// File: rtl/div_unit.sv
// Sequential signed divider (MIPS DIV) for the multicycle datapath.
// LO = quotient truncated toward zero, HI = remainder with the dividend's
// sign. Divide-by-zero finishes early with div0 set and HI/LO untouched.
// Build option: DIV_EARLY_TERM_EN - when |dividend| < |divisor| the result
// (LO=0, HI=dividend) is produced straight from SETUP.
module div_unit
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic       clk,
  input  logic       reset,
  div_unit_if.slave  bus
);

  div_state_t             r_state;
  div_state_t             w_next;

  logic [WIDTH-1:0]       r_dvd;
  logic [WIDTH-1:0]       r_dvs;
  logic [WIDTH-1:0]       r_rem;
  logic [WIDTH-1:0]       r_quo;
  logic [WIDTH-1:0]       r_dvs_mag;
  logic                   r_sign_q;
  logic                   r_sign_r;
  logic [DIV_CNT_W-1:0]   r_cnt;
  logic                   r_div0;
  logic [WIDTH-1:0]       r_hi;
  logic [WIDTH-1:0]       r_lo;

  logic [WIDTH-1:0]       w_dvd_mag;
  logic [WIDTH-1:0]       w_dvs_mag;
  logic                   w_dvs_zero;
  logic                   w_early;
  logic [WIDTH-1:0]       w_rem_nxt;
  logic [WIDTH-1:0]       w_quo_nxt;

  // Operand magnitudes as unsigned values; the most negative number maps to
  // its own bit pattern, which is the correct unsigned magnitude.
  always_comb begin
    w_dvd_mag  = r_dvd[WIDTH-1] ? (~r_dvd + 1'b1) : r_dvd;
    w_dvs_mag  = r_dvs[WIDTH-1] ? (~r_dvs + 1'b1) : r_dvs;
    w_dvs_zero = (r_dvs == '0);
`ifdef DIV_EARLY_TERM_EN
    w_early    = (w_dvd_mag < w_dvs_mag);
`else
    w_early    = 1'b0;
`endif
  end

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_dvs (r_dvs_mag),
    .o_rem (w_rem_nxt),
    .o_quo (w_quo_nxt)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; start is only honoured in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = SETUP;
      SETUP:   w_next = (w_dvs_zero || w_early) ? DONE : ITER;
      ITER:    if (r_cnt == DIV_CNT_W'(1)) w_next = FIX;
      FIX:     w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: operand capture, setup, iteration and sign fix-up into HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvs_mag <= '0;
      r_sign_q  <= 1'b0;
      r_sign_r  <= 1'b0;
      r_cnt     <= '0;
      r_div0    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_dvd <= bus.dividend;
            r_dvs <= bus.divisor;
          end
        end
        SETUP: begin
          r_sign_q  <= r_dvd[WIDTH-1] ^ r_dvs[WIDTH-1];
          r_sign_r  <= r_dvd[WIDTH-1];
          r_rem     <= '0;
          r_quo     <= w_dvd_mag;
          r_dvs_mag <= w_dvs_mag;
          r_cnt     <= DIV_CNT_W'(WIDTH);
          r_div0    <= w_dvs_zero;
          // Short path: quotient is zero and the remainder is the dividend itself.
          if (!w_dvs_zero && w_early) begin
            r_lo <= '0;
            r_hi <= r_dvd;
          end
        end
        ITER: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt - 1'b1;
        end
        FIX: begin
          r_lo <= r_sign_q ? (~r_quo + 1'b1) : r_quo;
          r_hi <= r_sign_r ? (~r_rem + 1'b1) : r_rem;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (r_state != IDLE);
  assign bus.done   = (r_state == DONE);
  assign bus.div0   = r_div0;
  assign bus.hi_out = r_hi;
  assign bus.lo_out = r_lo;

endmodule
